// File: rtl/ama_riscv_retire_tracker.sv
// ama_riscv_retire_tracker: carries exe-stage side information to retirement,
// buffers filtered trace records in a FWFT FIFO and keeps retirement statistics.
`default_nettype none

module ama_riscv_retire_tracker #(
   parameter int PIPE_STAGES   = 3,
   parameter int RESOLVE_STAGE = 1,
   parameter int FIFO_DEPTH    = 8,
   parameter int ARCH_WIDTH    = 32,
   parameter int INST_WIDTH    = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [PIPE_STAGES-1:0]           stage_en,
   input  logic [PIPE_STAGES-1:0]           stage_flush,
   input  logic                             ex_branch,
   input  logic                             ex_dmem_valid,
   input  logic                             ex_dmem_store,
   input  logic [1:0]                       ex_dmem_dtype,
   input  logic [ARCH_WIDTH-1:0]            ex_dmem_addr,
   input  logic                             res_taken,
   input  logic                             res_bp_hit,
   input  logic                             inst_retired,
   input  logic [INST_WIDTH-1:0]            ret_inst,
   input  logic [ARCH_WIDTH-1:0]            ret_pc,
   input  logic                             trace_en,
   input  logic [1:0]                       filter_mode,
   input  logic                             clr_cnt,
   output logic                             trace_valid,
   input  logic                             trace_ready,
   output logic [INST_WIDTH-1:0]            trace_inst,
   output logic [ARCH_WIDTH-1:0]            trace_pc,
   output logic                             trace_branch,
   output logic                             trace_taken,
   output logic                             trace_bp_hit,
   output logic [ARCH_WIDTH-1:0]            trace_dmem_addr,
   output logic [3:0]                       trace_dmem_size,
   output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
   output logic                             overflow,
   output logic [15:0]                      drop_cnt,
   output logic [31:0]                      cnt_ret,
   output logic [31:0]                      cnt_branch,
   output logic [31:0]                      cnt_taken,
   output logic [31:0]                      cnt_bp_hit,
   output logic [31:0]                      cnt_load,
   output logic [31:0]                      cnt_store
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int REC_W = INST_WIDTH + 2*ARCH_WIDTH + 3 + 4;
   localparam logic [3:0]       SIZE_NONE = 4'd8;
   localparam logic [REC_W-1:0] IDLE_REC  = {{(REC_W-4){1'b0}}, SIZE_NONE};

   // ---------------- tracked pipeline stages ----------------
   logic [PIPE_STAGES-1:0] br_q, br_d, tk_q, tk_d, hit_q, hit_d;
   logic [ARCH_WIDTH-1:0]  addr_q [PIPE_STAGES];
   logic [ARCH_WIDTH-1:0]  addr_d [PIPE_STAGES];
   logic [3:0]             size_q [PIPE_STAGES];
   logic [3:0]             size_d [PIPE_STAGES];

   always_comb begin
      br_d   = br_q;
      tk_d   = tk_q;
      hit_d  = hit_q;
      addr_d = addr_q;
      size_d = size_q;
      if (stage_en[0]) begin
         tk_d[0]  = 1'b0;
         hit_d[0] = 1'b0;
         if (stage_flush[0] || !ex_dmem_valid) begin
            addr_d[0] = '0;
            size_d[0] = SIZE_NONE;
         end else begin
            addr_d[0] = ex_dmem_addr;
            size_d[0] = {1'b0, ex_dmem_store, ex_dmem_dtype};
         end
         br_d[0] = ex_branch & ~stage_flush[0];
      end
      for (int i = 1; i < PIPE_STAGES; i++) begin
         if (stage_en[i]) begin
            if (stage_flush[i]) begin
               br_d[i]   = 1'b0;
               tk_d[i]   = 1'b0;
               hit_d[i]  = 1'b0;
               addr_d[i] = '0;
               size_d[i] = SIZE_NONE;
            end else begin
               br_d[i]   = br_q[i-1];
               addr_d[i] = addr_q[i-1];
               size_d[i] = size_q[i-1];
               // Resolution is sampled only as a record enters the resolve stage
               if (i == RESOLVE_STAGE) begin
                  tk_d[i]  = res_taken  & br_q[i-1];
                  hit_d[i] = res_bp_hit & br_q[i-1];
               end else begin
                  tk_d[i]  = tk_q[i-1];
                  hit_d[i] = hit_q[i-1];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_q  <= '0;
         tk_q  <= '0;
         hit_q <= '0;
         for (int i = 0; i < PIPE_STAGES; i++) begin
            addr_q[i] <= '0;
            size_q[i] <= SIZE_NONE;
         end
      end else begin
         br_q   <= br_d;
         tk_q   <= tk_d;
         hit_q  <= hit_d;
         addr_q <= addr_d;
         size_q <= size_d;
      end
   end

   // ---------------- retirement record and filter ----------------
   logic                  ret_br, ret_tk, ret_hit, ret_dmem, ret_load, ret_store;
   logic [3:0]            ret_size;
   logic                  filt_match, push_req, push_ok, pop, full, drop;

   assign ret_br    = br_q[PIPE_STAGES-1];
   assign ret_tk    = tk_q[PIPE_STAGES-1];
   assign ret_hit   = hit_q[PIPE_STAGES-1];
   assign ret_size  = size_q[PIPE_STAGES-1];
   assign ret_dmem  = (ret_size != SIZE_NONE);
   assign ret_load  = ~ret_size[3] & ~ret_size[2];
   assign ret_store = ~ret_size[3] &  ret_size[2];

   always_comb begin
      filt_match = 1'b1;
      case (filter_mode)
         2'd1:    filt_match = ret_br;
         2'd2:    filt_match = ret_dmem;
         2'd3:    filt_match = ret_br | ret_dmem;
         default: filt_match = 1'b1;
      endcase
   end

   // ---------------- trace FIFO ----------------
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [REC_W-1:0] mem_q [FIFO_DEPTH];
   logic [REC_W-1:0] head;

   assign trace_valid = (level_q != '0);
   assign full        = (level_q == LVL_W'(FIFO_DEPTH));
   assign pop         = trace_valid & trace_ready;
   assign push_req    = inst_retired & trace_en & filt_match;
   // A full FIFO still accepts a push when the head leaves on the same edge
   assign push_ok     = push_req & (~full | pop);
   assign drop        = push_req & full & ~pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem_q[wr_ptr_q] <= {ret_inst, ret_pc, ret_br, ret_tk, ret_hit,
                             addr_q[PIPE_STAGES-1], ret_size};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign head = trace_valid ? mem_q[rd_ptr_q] : IDLE_REC;
   assign {trace_inst, trace_pc, trace_branch, trace_taken, trace_bp_hit,
           trace_dmem_addr, trace_dmem_size} = head;
   assign fifo_level = level_q;

   // ---------------- statistics ----------------
   logic [31:0] cnt_ret_q, cnt_ret_d, cnt_br_q, cnt_br_d, cnt_tk_q, cnt_tk_d;
   logic [31:0] cnt_hit_q, cnt_hit_d, cnt_ld_q, cnt_ld_d, cnt_st_q, cnt_st_d;
   logic [15:0] drop_q, drop_d;
   logic        ovf_q, ovf_d;

   always_comb begin
      cnt_ret_d = cnt_ret_q;
      cnt_br_d  = cnt_br_q;
      cnt_tk_d  = cnt_tk_q;
      cnt_hit_d = cnt_hit_q;
      cnt_ld_d  = cnt_ld_q;
      cnt_st_d  = cnt_st_q;
      drop_d    = drop_q;
      ovf_d     = ovf_q;
      if (clr_cnt) begin
         cnt_ret_d = '0;
         cnt_br_d  = '0;
         cnt_tk_d  = '0;
         cnt_hit_d = '0;
         cnt_ld_d  = '0;
         cnt_st_d  = '0;
         drop_d    = '0;
         ovf_d     = 1'b0;
      end else begin
         if (inst_retired) begin
            cnt_ret_d = cnt_ret_q + 32'd1;
            if (ret_br)    cnt_br_d  = cnt_br_q  + 32'd1;
            if (ret_tk)    cnt_tk_d  = cnt_tk_q  + 32'd1;
            if (ret_hit)   cnt_hit_d = cnt_hit_q + 32'd1;
            if (ret_load)  cnt_ld_d  = cnt_ld_q  + 32'd1;
            if (ret_store) cnt_st_d  = cnt_st_q  + 32'd1;
         end
         if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_ret_q <= '0;
         cnt_br_q  <= '0;
         cnt_tk_q  <= '0;
         cnt_hit_q <= '0;
         cnt_ld_q  <= '0;
         cnt_st_q  <= '0;
         drop_q    <= '0;
         ovf_q     <= 1'b0;
      end else begin
         cnt_ret_q <= cnt_ret_d;
         cnt_br_q  <= cnt_br_d;
         cnt_tk_q  <= cnt_tk_d;
         cnt_hit_q <= cnt_hit_d;
         cnt_ld_q  <= cnt_ld_d;
         cnt_st_q  <= cnt_st_d;
         drop_q    <= drop_d;
         ovf_q     <= ovf_d;
      end
   end

   assign overflow   = ovf_q;
   assign drop_cnt   = drop_q;
   assign cnt_ret    = cnt_ret_q;
   assign cnt_branch = cnt_br_q;
   assign cnt_taken  = cnt_tk_q;
   assign cnt_bp_hit = cnt_hit_q;
   assign cnt_load   = cnt_ld_q;
   assign cnt_store  = cnt_st_q;

endmodule

`default_nettype wire

// File: tb/tb_ama_riscv_retire_tracker.sv
// Randomized bench for ama_riscv_retire_tracker against a queue-based reference model.
`default_nettype none

module tb_ama_riscv_retire_tracker;
   localparam int P  = 3;
   localparam int RS = 1;
   localparam int D  = 8;

   logic        clk, rst_n;
   logic [P-1:0] stage_en, stage_flush;
   logic        ex_branch, ex_dmem_valid, ex_dmem_store;
   logic [1:0]  ex_dmem_dtype;
   logic [31:0] ex_dmem_addr;
   logic        res_taken, res_bp_hit, inst_retired;
   logic [31:0] ret_inst, ret_pc;
   logic        trace_en, clr_cnt, trace_valid, trace_ready;
   logic [1:0]  filter_mode;
   logic [31:0] trace_inst, trace_pc, trace_dmem_addr;
   logic        trace_branch, trace_taken, trace_bp_hit, overflow;
   logic [3:0]  trace_dmem_size;
   logic [3:0]  fifo_level;
   logic [15:0] drop_cnt;
   logic [31:0] cnt_ret, cnt_branch, cnt_taken, cnt_bp_hit, cnt_load, cnt_store;

   ama_riscv_retire_tracker #(.PIPE_STAGES(P), .RESOLVE_STAGE(RS), .FIFO_DEPTH(D),
                              .ARCH_WIDTH(32), .INST_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .stage_en(stage_en), .stage_flush(stage_flush),
      .ex_branch(ex_branch), .ex_dmem_valid(ex_dmem_valid), .ex_dmem_store(ex_dmem_store),
      .ex_dmem_dtype(ex_dmem_dtype), .ex_dmem_addr(ex_dmem_addr),
      .res_taken(res_taken), .res_bp_hit(res_bp_hit), .inst_retired(inst_retired),
      .ret_inst(ret_inst), .ret_pc(ret_pc), .trace_en(trace_en), .filter_mode(filter_mode),
      .clr_cnt(clr_cnt), .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_inst(trace_inst), .trace_pc(trace_pc), .trace_branch(trace_branch),
      .trace_taken(trace_taken), .trace_bp_hit(trace_bp_hit),
      .trace_dmem_addr(trace_dmem_addr), .trace_dmem_size(trace_dmem_size),
      .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt),
      .cnt_ret(cnt_ret), .cnt_branch(cnt_branch), .cnt_taken(cnt_taken),
      .cnt_bp_hit(cnt_bp_hit), .cnt_load(cnt_load), .cnt_store(cnt_store));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct { bit br; bit tk; bit hit; bit [31:0] addr; bit [3:0] size; } srec_t;
   typedef struct { bit [31:0] inst; bit [31:0] pc; srec_t s; } trec_t;

   srec_t       st [P];
   trec_t       q [$];
   bit [31:0]   m_ret, m_br, m_tk, m_hit, m_ld, m_st;
   bit          m_ovf;
   int          m_drop;
   int          n_vec, n_err;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic srec_t none_rec();
      srec_t r;
      r.br = 0; r.tk = 0; r.hit = 0; r.addr = 0; r.size = 4'd8;
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < P; i++) st[i] = none_rec();
      q.delete();
      m_ret = 0; m_br = 0; m_tk = 0; m_hit = 0; m_ld = 0; m_st = 0;
      m_ovf = 0; m_drop = 0;
   endtask

   task automatic model_step();
      srec_t r;
      trec_t t;
      bit    dm, match, push, pop, full;
      r     = st[P-1];
      dm    = (r.size != 4'd8);
      case (filter_mode)
         2'd0: match = 1;
         2'd1: match = r.br;
         2'd2: match = dm;
         default: match = r.br || dm;
      endcase
      push = inst_retired && trace_en && match;
      pop  = (q.size() != 0) && trace_ready;
      full = (q.size() == D);
      if (clr_cnt) begin
         m_ret = 0; m_br = 0; m_tk = 0; m_hit = 0; m_ld = 0; m_st = 0;
         m_ovf = 0; m_drop = 0;
      end else begin
         if (inst_retired) begin
            m_ret++;
            if (r.br)  m_br++;
            if (r.tk)  m_tk++;
            if (r.hit) m_hit++;
            if (r.size < 4)      m_ld++;
            else if (r.size < 8) m_st++;
         end
         if (push && full && !pop) begin
            m_ovf = 1;
            if (m_drop < 65535) m_drop++;
         end
      end
      if (pop) void'(q.pop_front());
      if (push && !(full && !pop)) begin
         t.inst = ret_inst; t.pc = ret_pc; t.s = r;
         q.push_back(t);
      end
      for (int i = P-1; i >= 1; i--) begin
         if (stage_en[i]) begin
            if (stage_flush[i]) st[i] = none_rec();
            else begin
               st[i] = st[i-1];
               if (i == RS) begin
                  st[i].tk  = res_taken  && st[i-1].br;
                  st[i].hit = res_bp_hit && st[i-1].br;
               end
            end
         end
      end
      if (stage_en[0]) begin
         st[0] = none_rec();
         if (!stage_flush[0]) begin
            st[0].br = ex_branch;
            if (ex_dmem_valid) begin
               st[0].addr = ex_dmem_addr;
               st[0].size = {1'b0, ex_dmem_store, ex_dmem_dtype};
            end
         end
      end
   endtask

   task automatic check_all();
      trec_t h;
      check("valid", trace_valid, q.size() != 0);
      if (q.size() != 0) h = q[0];
      else begin h.inst = 0; h.pc = 0; h.s = none_rec(); end
      check("inst",   trace_inst,      h.inst);
      check("pc",     trace_pc,        h.pc);
      check("branch", trace_branch,    h.s.br);
      check("taken",  trace_taken,     h.s.tk);
      check("bphit",  trace_bp_hit,    h.s.hit);
      check("addr",   trace_dmem_addr, h.s.addr);
      check("size",   trace_dmem_size, h.s.size);
      check("level",  fifo_level,      q.size());
      check("ovf",    overflow,        m_ovf);
      check("drop",   drop_cnt,        m_drop);
      check("c_ret",  cnt_ret,   m_ret);
      check("c_br",   cnt_branch, m_br);
      check("c_tk",   cnt_taken, m_tk);
      check("c_hit",  cnt_bp_hit, m_hit);
      check("c_ld",   cnt_load,  m_ld);
      check("c_st",   cnt_store, m_st);
   endtask

   // Inputs are driven at the falling edge; the model steps at the rising edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      stage_en = '1; stage_flush = '0;
      ex_branch = 0; ex_dmem_valid = 0; ex_dmem_store = 0; ex_dmem_dtype = 0; ex_dmem_addr = 0;
      res_taken = 0; res_bp_hit = 0; inst_retired = 0; ret_inst = 0; ret_pc = 0;
      trace_en = 1; filter_mode = 0; clr_cnt = 0;
   endtask

   task automatic drain();
      idle();
      trace_ready = 1;
      for (int k = 0; k < 2*D && q.size() != 0; k++) tick();
      check("drained", fifo_level, 0);
   endtask

   task automatic rand_in(input int ready_pct);
      for (int i = 0; i < P; i++) begin
         stage_en[i]    = ($urandom_range(0, 3) != 0);
         stage_flush[i] = ($urandom_range(0, 9) == 0);
      end
      ex_branch     = $urandom_range(0, 1);
      ex_dmem_valid = $urandom_range(0, 1);
      ex_dmem_store = $urandom_range(0, 1);
      ex_dmem_dtype = 2'($urandom_range(0, 3));
      ex_dmem_addr  = $urandom;
      res_taken     = $urandom_range(0, 1);
      res_bp_hit    = $urandom_range(0, 1);
      inst_retired  = $urandom_range(0, 1);
      ret_inst      = $urandom;
      ret_pc        = $urandom;
      trace_en      = ($urandom_range(0, 7) != 0);
      clr_cnt       = ($urandom_range(0, 63) == 0);
      trace_ready   = ($urandom_range(1, 100) <= ready_pct);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      idle();
      trace_ready = 0;
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all();
      rst_n = 1;

      // Store travels three stages and retires
      ex_dmem_valid = 1; ex_dmem_store = 1; ex_dmem_dtype = 2; ex_dmem_addr = 32'h1000;
      tick();
      idle(); tick(); tick();
      inst_retired = 1; ret_pc = 32'h80; ret_inst = 32'h00a12023;
      tick();
      check("st_size",  trace_dmem_size, 6);
      check("st_addr",  trace_dmem_addr, 32'h1000);
      check("st_valid", trace_valid, 1);
      check("st_cnt",   cnt_store, 1);

      // Taken, predicted branch followed by a load that gets flushed in stage 2
      drain(); trace_ready = 0;
      ex_branch = 1; tick();
      idle(); ex_dmem_valid = 1; ex_dmem_addr = 32'h2000; res_taken = 1; res_bp_hit = 1; tick();
      idle(); tick();
      inst_retired = 1; stage_flush[2] = 1; tick();
      check("br_b",  trace_branch, 1);
      check("br_t",  trace_taken,  1);
      check("br_h",  trace_bp_hit, 1);
      idle(); inst_retired = 1; tick();
      idle(); trace_ready = 1; tick();
      check("fl_size", trace_dmem_size, 8);
      check("fl_br",   trace_branch, 0);

      // Overflow: nine retirements into an eight-entry FIFO, then push+pop while full
      drain(); clr_cnt = 1; tick();
      idle(); trace_ready = 0; inst_retired = 1;
      repeat (9) tick();
      check("of_lvl", fifo_level, 8);
      check("of_ovf", overflow, 1);
      check("of_drp", drop_cnt, 1);
      check("of_ret", cnt_ret, 9);
      trace_ready = 1; tick();
      check("pp_lvl", fifo_level, 8);
      check("pp_drp", drop_cnt, 1);

      // Branch-only filter on an alternating ALU/branch stream
      drain(); clr_cnt = 1; tick();
      idle(); trace_ready = 0; filter_mode = 1;
      for (int k = 0; k < 13; k++) begin
         ex_branch    = (k < 10) && k[0];
         inst_retired = (k >= 3);
         ret_pc       = 32'h100 + 4*k;
         tick();
      end
      check("fm_lvl", fifo_level, 5);
      check("fm_ret", cnt_ret, 10);
      check("fm_br",  cnt_branch, 5);

      // Stage 1 stalled for four cycles, then clear racing a retirement
      drain();
      for (int k = 0; k < 12; k++) begin
         rand_in(50);
         stage_flush = '0; clr_cnt = 0;
         if (k >= 4 && k < 8) stage_en[1] = 0;
         tick();
      end
      idle(); inst_retired = 1; clr_cnt = 1; tick();
      check("clr_ret", cnt_ret, 0);

      // Randomized phases with each filter mode and varying back-pressure
      for (int ph = 0; ph < 8; ph++) begin
         for (int k = 0; k < 300; k++) begin
            rand_in((ph % 4) * 30 + 5);
            filter_mode = 2'(ph);
            tick();
         end
      end

      // Asynchronous reset with entries queued
      drain(); trace_ready = 0; inst_retired = 1;
      repeat (3) tick();
      check("ar_pre", fifo_level, 3);
      idle();
      #2 rst_n = 0;
      #1;
      check("ar_valid", trace_valid, 0);
      check("ar_level", fifo_level, 0);
      model_reset();
      @(negedge clk);
      check_all();
      rst_n = 1;
      for (int k = 0; k < 50; k++) begin
         rand_in(60);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

`default_nettype wire
